// File: rtl/fp_sched_if.sv
// fp_sched_if: bundles the requester-side and core-side signals of the
// shared fp_add/fp_mul scheduler.
//   slave  : the scheduler (drives ack/result/grant and the core controls)
//   master : the environment (requesters plus the fp_add/fp_mul cores)
// Operand buses pack requester i at bits [32*i+31:32*i].
interface fp_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      op;
    logic [32*NREQ-1:0]   opa;
    logic [32*NREQ-1:0]   opb;
    logic [NREQ-1:0]      ack;
    logic [31:0]          result;
    logic                 timeout_err;
    logic                 busy;
    logic [NREQ-1:0]      grant;
    logic                 fp_restart;
    logic                 fp_start;
    logic [31:0]          fp_n1;
    logic [31:0]          fp_n2;
    logic [31:0]          fp_sum;
    logic [31:0]          fp_prod;
    logic                 fp_add_done;
    logic                 fp_mul_done;

    modport slave (
        input  req, op, opa, opb, fp_sum, fp_prod, fp_add_done, fp_mul_done,
        output ack, result, timeout_err, busy, grant,
               fp_restart, fp_start, fp_n1, fp_n2
    );

    modport master (
        output req, op, opa, opb, fp_sum, fp_prod, fp_add_done, fp_mul_done,
        input  ack, result, timeout_err, busy, grant,
               fp_restart, fp_start, fp_n1, fp_n2
    );
endinterface

// File: rtl/fp_sched.sv
// fp_sched: round-robin owner of the shared fp_add/fp_mul core pair.
// Picks one requester, latches its operands, runs the restart/start/done
// handshake on the cores, returns the result with a one-cycle ack, and
// aborts with a quiet NaN if the watched core never reports done.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   reset    - synchronous, active-high
//   bus      - fp_sched_if.slave: requester req/op/opa/opb -> ack/result/
//              timeout_err/busy/grant, and core fp_restart/fp_start/fp_n1/
//              fp_n2 -> fp_sum/fp_prod/fp_add_done/fp_mul_done
//
// state   | meaning
// IDLE    | no owner; scan req from ptr, latch winner's op and operands
// RESTART | hold cores in restart for one cycle, arm watchdog
// RUN     | cores started; wait for watched done or watchdog expiry
// RESP    | one-cycle ack to owner, advance round-robin pointer
module fp_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic      CLOCK_50,
    input  logic      reset,
    fp_sched_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, RESTART, RUN, RESP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt, owner, owner_nxt;
    logic            op_l, op_nxt, abort, abort_nxt;
    logic [WW-1:0]   wdog, wdog_nxt;
    logic [31:0]     n1_q, n1_nxt, n2_q, n2_nxt, result_q, result_nxt;
    logic [NREQ-1:0] ack_q, ack_nxt, grant_q, grant_nxt, owner_oh;
    logic            busy_q, busy_nxt, terr_q, terr_nxt;
    logic            restart_q, restart_nxt, start_q, start_nxt;
    logic            found, watched_done;
    logic [PW:0]     scan;
    logic [31:0]     opa_arr [NREQ];
    logic [31:0]     opb_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign opa_arr[g] = bus.opa[32*g +: 32];
        assign opb_arr[g] = bus.opb[32*g +: 32];
    end

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        op_nxt       = op_l;
        abort_nxt    = abort;
        wdog_nxt     = wdog;
        n1_nxt       = n1_q;
        n2_nxt       = n2_q;
        result_nxt   = result_q;
        found        = 1'b0;
        scan         = '0;
        watched_done = op_l ? bus.fp_mul_done : bus.fp_add_done;

        case (state)
            IDLE: begin
                // First set req at ptr, ptr+1, ... wrapping mod NREQ.
                for (int i = 0; i < NREQ; i++) begin
                    scan = {1'b0, ptr} + (PW+1)'(i);
                    if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
                    if (!found && bus.req[scan[PW-1:0]]) begin
                        found     = 1'b1;
                        owner_nxt = scan[PW-1:0];
                    end
                end
                if (found) begin
                    op_nxt    = bus.op[owner_nxt];
                    n1_nxt    = opa_arr[owner_nxt];
                    n2_nxt    = opb_arr[owner_nxt];
                    abort_nxt = 1'b0;
                    state_nxt = RESTART;
                end
            end
            RESTART: begin
                // Down-counter: reaching zero on RUN's TIMEOUT-th cycle aborts.
                wdog_nxt  = WW'(TIMEOUT - 1);
                state_nxt = RUN;
            end
            RUN: begin
                if (watched_done) begin
                    result_nxt = op_l ? bus.fp_prod : bus.fp_sum;
                    state_nxt  = RESP;
                end else if (wdog == '0) begin
                    result_nxt = 32'h7FC0_0000;
                    abort_nxt  = 1'b1;
                    state_nxt  = RESP;
                end else begin
                    wdog_nxt = wdog - 1'b1;
                end
            end
            RESP: begin
                ptr_nxt   = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so they are derived from the next state.
        owner_oh    = NREQ'(1) << owner_nxt;
        busy_nxt    = (state_nxt != IDLE);
        grant_nxt   = (state_nxt != IDLE) ? owner_oh : '0;
        ack_nxt     = (state_nxt == RESP) ? owner_oh : '0;
        terr_nxt    = (state_nxt == RESP) && abort_nxt;
        restart_nxt = (state_nxt != RUN);
        start_nxt   = (state_nxt == RUN);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            op_l      <= 1'b0;
            abort     <= 1'b0;
            wdog      <= '0;
            n1_q      <= '0;
            n2_q      <= '0;
            result_q  <= '0;
            ack_q     <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
            restart_q <= 1'b1;
            start_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            owner     <= owner_nxt;
            op_l      <= op_nxt;
            abort     <= abort_nxt;
            wdog      <= wdog_nxt;
            n1_q      <= n1_nxt;
            n2_q      <= n2_nxt;
            result_q  <= result_nxt;
            ack_q     <= ack_nxt;
            grant_q   <= grant_nxt;
            busy_q    <= busy_nxt;
            terr_q    <= terr_nxt;
            restart_q <= restart_nxt;
            start_q   <= start_nxt;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant       = grant_q;
    assign bus.result      = result_q;
    assign bus.timeout_err = terr_q;
    assign bus.busy        = busy_q;
    assign bus.fp_restart  = restart_q;
    assign bus.fp_start    = start_q;
    assign bus.fp_n1       = n1_q;
    assign bus.fp_n2       = n2_q;
endmodule

// File: tb/tb_fp_sched.sv
// tb_fp_sched: scoreboard bench for fp_sched. Expected acks (owner, result,
// abort flag, cycle) are queued when a request is driven and popped by a
// monitor whenever the DUT pulses ack. A small core model answers the
// restart/start handshake with per-core programmable done delays.
module tb_fp_sched;
    localparam int NREQ    = 2;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fp_sched_if #(.NREQ(NREQ)) bus ();

    fp_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        terr;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   add_dly = 0;
    int   mul_dly = 0;
    int   cnt     = 0;
    logic prev_restart = 1'b1;
    logic prev_start   = 1'b0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Known-answer tables for the vectors used here; anything else gets a
    // distinct non-FP token so add and multiply never coincide.
    function automatic logic [31:0] ref_add(logic [31:0] a, logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h40000000, 32'h40400000}: return 32'h40A00000;
            default:                      return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h3F800000, 32'h40000000}: return 32'h40000000;
            {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
            default:                      return a + b;
        endcase
    endfunction

    function automatic logic [NREQ-1:0] onehot(int i);
        return NREQ'(1) << i;
    endfunction

    assign bus.fp_sum  = ref_add(bus.fp_n1, bus.fp_n2);
    assign bus.fp_prod = ref_mul(bus.fp_n1, bus.fp_n2);

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: done (level) rises on the delay-th cycle of fp_start.
    always @(negedge clk) begin
        if (bus.fp_restart) cnt = 0;
        else if (bus.fp_start) cnt = cnt + 1;
        bus.fp_add_done = (add_dly != 0) && (cnt >= add_dly);
        bus.fp_mul_done = (mul_dly != 0) && (cnt >= mul_dly);
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.fp_start && !prev_start)
                check("restart_before_start", 32'(prev_restart), 32'd1);
            if (|bus.ack) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'(bus.ack), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_vec", 32'(bus.ack), 32'(onehot(mon_e.owner)));
                    check("result", bus.result, mon_e.res);
                    check("timeout_err", 32'(bus.timeout_err), 32'(mon_e.terr));
                    check("ack_cycle", cyc, mon_e.cyc);
                end
            end else if (bus.timeout_err) begin
                check("terr_without_ack", 32'(bus.timeout_err), 32'd0);
            end
        end
        prev_restart = bus.fp_restart;
        prev_start   = bus.fp_start;
    end

    task automatic wait_ack(int owner, int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (bus.ack[owner]) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("ack_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ack"},     32'(bus.ack), 32'd0);
        check({tag, "_grant"},   32'(bus.grant), 32'd0);
        check({tag, "_result"},  bus.result, 32'd0);
        check({tag, "_terr"},    32'(bus.timeout_err), 32'd0);
        check({tag, "_busy"},    32'(bus.busy), 32'd0);
        check({tag, "_restart"}, 32'(bus.fp_restart), 32'd1);
        check({tag, "_start"},   32'(bus.fp_start), 32'd0);
        check({tag, "_n1"},      bus.fp_n1, 32'd0);
        check({tag, "_n2"},      bus.fp_n2, 32'd0);
    endtask

    // Called at #1 after a rising edge with the DUT idle.
    task automatic do_op(int owner, logic opv, logic [31:0] a, logic [31:0] b,
                         int adly, int mdly, bit mangle);
        exp_t e;
        int   k;
        add_dly = adly;
        mul_dly = mdly;
        k       = opv ? mdly : adly;
        e.owner = owner;
        e.terr  = 1'b0;
        if (k == 0 || k > TIMEOUT) begin
            k      = TIMEOUT;
            e.terr = 1'b1;
            e.res  = 32'h7FC00000;
        end else begin
            e.res = opv ? ref_mul(a, b) : ref_add(a, b);
        end
        e.cyc = cyc + k + 2;
        sb.push_back(e);
        bus.op[owner]            = opv;
        bus.opa[32*owner +: 32]  = a;
        bus.opb[32*owner +: 32]  = b;
        bus.req[owner]           = 1'b1;
        @(posedge clk); #1;
        check("grant", 32'(bus.grant), 32'(onehot(owner)));
        check("busy", 32'(bus.busy), 32'd1);
        check("restart_phase_restart", 32'(bus.fp_restart), 32'd1);
        check("restart_phase_start", 32'(bus.fp_start), 32'd0);
        @(posedge clk); #1;
        check("run_start", 32'(bus.fp_start), 32'd1);
        check("run_restart", 32'(bus.fp_restart), 32'd0);
        check("run_n1", bus.fp_n1, a);
        check("run_n2", bus.fp_n2, b);
        if (mangle) begin
            bus.opa[32*owner +: 32] = 32'h12345678;
            bus.opb[32*owner +: 32] = 32'h0;
            bus.op[owner]           = ~opv;
            bus.req[owner]          = 1'b0;
        end
        wait_ack(owner, TIMEOUT + 10);
        bus.req[owner] = 1'b0;
        @(posedge clk); #1;
        check("ack_single_cycle", 32'(bus.ack), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_grant", 32'(bus.grant), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] ack_seen;
        exp_t e;
        int   c0;
        reset   = 1'b1;
        bus.req = '0;
        bus.op  = '0;
        bus.opa = '0;
        bus.opb = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Single add on requester 0, spurious early mul done.
        do_op(0, 1'b0, 32'h3F800000, 32'h40000000, 4, 2, 1'b0);
        // Multiply on requester 1, spurious early add done.
        do_op(1, 1'b1, 32'h40000000, 32'h40400000, 1, 5, 1'b0);

        // Fairness: both requesting continuously, ptr = 0.
        add_dly = 3;
        mul_dly = 0;
        bus.op  = '0;
        bus.opa[31:0]  = 32'h3F800000;  bus.opb[31:0]  = 32'h40000000;
        bus.opa[63:32] = 32'h3F800000;  bus.opb[63:32] = 32'h3F800000;
        c0 = cyc;
        for (int n = 0; n < 4; n++) begin
            e.owner = n % 2;
            e.terr  = 1'b0;
            e.res   = (n % 2 == 0) ? 32'h40400000 : 32'h40000000;
            e.cyc   = c0 + 5 + 6 * n;
            sb.push_back(e);
        end
        bus.req = '1;
        for (int n = 0; n < 4; n++) wait_ack(n % 2, 20);
        bus.req = '0;
        repeat (2) @(posedge clk);
        #1;
        check("fair_drain", sb.size(), 32'd0);

        // Watchdog abort, then a normal op afterwards.
        do_op(0, 1'b0, 32'h3F800000, 32'h40000000, 0, 3, 1'b0);
        do_op(1, 1'b0, 32'h3F800000, 32'h3F800000, 2, 0, 1'b0);

        // Operand/op change and req drop after capture.
        do_op(0, 1'b1, 32'h40000000, 32'h40400000, 2, 4, 1'b1);

        // Reset in RUN with ptr = 1.
        add_dly = 10;
        mul_dly = 0;
        bus.op[0]     = 1'b0;
        bus.opa[31:0] = 32'h3F800000;
        bus.opb[31:0] = 32'h40000000;
        bus.req[0]    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("run_before_reset", 32'(bus.fp_start), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_in_run");
        reset      = 1'b0;
        bus.req[0] = 1'b0;
        ack_seen   = '0;
        repeat (15) begin
            @(posedge clk); #1;
            ack_seen = ack_seen | bus.ack;
        end
        check("no_ack_after_reset", 32'(ack_seen), 32'd0);

        // After reset ptr is 0: requester 0 wins over 1.
        add_dly = 2;
        bus.op  = '0;
        bus.opa[63:32] = 32'h3F800000;
        bus.opb[63:32] = 32'h3F800000;
        e.owner = 0;
        e.terr  = 1'b0;
        e.res   = 32'h40400000;
        e.cyc   = cyc + 4;
        sb.push_back(e);
        bus.req = '1;
        wait_ack(0, 20);
        bus.req = '0;
        repeat (3) @(posedge clk);
        #1;
        check("final_drain", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end
endmodule
